alu_seq_nbit: RTL and testbench

Parametrised multi-cycle N-bit ALU, successor to the single-bit slice datapath. It accepts one operation through a valid/ready handshake and processes the operands SLICE bits per clock, least-significant slice first, rippling carry through a register. It presents the result plus flags through a second valid/ready handshake. It sits between the register-file read stage and write-back wherever a small-area, multi-cycle ALU is acceptable.

---
 rtl/alu_seq_nbit_pkg.sv | 27 ++
 rtl/alu_seq_nbit_if.sv | 28 ++
 rtl/alu_seq_nbit_slice.sv | 35 +++
 rtl/alu_seq_nbit.sv | 133 +++++++++++++
 tb/tb_alu_seq_nbit.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_nbit_pkg.sv
// Shared definitions for the multi-cycle N-bit ALU: opcodes, FSM states and
// opcode classification helpers.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes with no defined operation; they produce a zero result.
    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    endfunction

    // Opcodes that use the adder and therefore produce carry/overflow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_seq_nbit_if.sv
// Request/response bundle of the multi-cycle ALU. The master offers an
// operation and consumes the result; the slave is the ALU itself.
interface alu_seq_nbit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, c_out, overflow, zero, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, c_out, overflow, zero, illegal
    );
endinterface

// File: rtl/alu_seq_nbit_slice.sv
// One SLICE-bit ALU slice. Purely combinational; the top time-multiplexes a
// single instance across all slices of the operands.
module alu_slice
    import alu_seq_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] r,
    output logic             cout,
    output logic             c_msb_in
);
    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum;

    // Slice add (with B inverted for SUB/SLT) and bitwise result select.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        r        = '0;
        b_eff    = b ^ {SLICE{op[2]}};
        sum      = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
        cout     = sum[SLICE];
        // Carry into the slice MSB recovered from the MSB sum bit.
        c_msb_in = a[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
        case (op)
            OP_ADD, OP_SUB, OP_SLT: r = sum[SLICE-1:0];
            OP_AND:                 r = a & b;
            OP_OR:                  r = a | b;
            default:                r = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq_nbit.sv
// Multi-cycle N-bit ALU: accepts an operation, processes SLICE bits per clock
// LSB slice first with a registered ripple carry, then holds the result and
// flags until the consumer takes them.
module alu_seq_nbit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input logic          clk,
    input logic          rst,
    alu_seq_nbit_if.slave bus
);
    // WIDTH must be a multiple of SLICE.
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             c_out_q;
    logic             ovf_q;
    logic             ill_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_r;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             accept;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign slice_a = a_q[int'(idx)*SLICE +: SLICE];
    assign slice_b = b_q[int'(idx)*SLICE +: SLICE];

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (carry_q),
        .op       (op_q),
        .r        (slice_r),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    // Operand capture on accept.
    // NOTE: operand registers carry no reset; they are always loaded before CALC reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
        end
    end

    // Control FSM with result/flag registers; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            idx         <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        idx        <= '0;
                        res_q      <= '0;
                        carry_q    <= bus.op[2];
                        c_out_q    <= 1'b0;
                        ovf_q      <= 1'b0;
                        ill_q      <= is_illegal(bus.op);
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    res_q[int'(idx)*SLICE +: SLICE] <= slice_r;
                    if (is_arith(op_q)) begin
                        carry_q <= slice_cout;
                    end
                    if (idx == LAST_IDX) begin
                        if (is_arith(op_q)) begin
                            c_out_q <= slice_cout;
                            ovf_q   <= slice_cmsb ^ slice_cout;
                        end
                        // SLT: signed less-than = sign of difference XOR overflow.
                        if (op_q == OP_SLT) begin
                            res_q <= WIDTH'(slice_r[SLICE-1] ^ slice_cmsb ^ slice_cout);
                        end
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
    assign bus.zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit: directed corner cases, randomized
// operations against an arithmetic reference model, backpressure, back-to-back
// issue, mid-operation reset and the single-slice configuration.
module tb_alu_seq_nbit;
    import alu_seq_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SLICE   = 4;
    localparam int NSLICES = WIDTH / SLICE;
    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic [31:0] result;
        logic        c_out;
        logic        overflow;
        logic        zero;
        logic        illegal;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_seq_nbit_if #(.WIDTH(WIDTH)) bus ();
    alu_seq_nbit_if #(.WIDTH(WIDTH)) bus1 ();

    alu_seq_nbit #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_seq_nbit #(.WIDTH(WIDTH), .SLICE(WIDTH)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Reference: plain 32-bit arithmetic and signed comparison.
    function automatic resp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        resp_t       r;
        logic [32:0] wide;
        r = '0;
        case (o)
            OP_ADD: begin
                wide       = {1'b0, x} + {1'b0, y};
                r.result   = wide[31:0];
                r.c_out    = wide[32];
                r.overflow = (x[31] == y[31]) && (r.result[31] != x[31]);
            end
            OP_SUB, OP_SLT: begin
                r.result   = x - y;
                r.c_out    = (x >= y);
                r.overflow = (x[31] != y[31]) && (r.result[31] != x[31]);
                if (o == OP_SLT) r.result = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            end
            OP_AND:  r.result = x & y;
            OP_OR:   r.result = x | y;
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    function automatic resp_t observe();
        return {bus.result, bus.c_out, bus.overflow, bus.zero, bus.illegal};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [4];
        corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
        return $urandom;
    endfunction

    // Offer one operation, then wait for out_valid; lat counts edges after accept.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < TIMEOUT) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resp_t exp;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp = '{result: 32'd0, c_out: 1'b0, overflow: 1'b0, zero: 1'b1, illegal: 1'b0};
        total++;
        if (observe() !== exp) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", observe(), exp);
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [9];
        logic [31:0] as  [9];
        logic [31:0] bs  [9];
        logic [35:0] exps[9];
        int          lat;
        ops = '{OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLT, OP_SLT, OP_AND, OP_OR, 3'b011};
        as  = '{32'h7FFF_FFFF, 32'd5, 32'd0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF,
                32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
        bs  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
        // {result, c_out, overflow, zero, illegal}
        exps = '{{32'h8000_0000, 4'b0100}, {32'h0000_0000, 4'b1010}, {32'hFFFF_FFFF, 4'b0000},
                 {32'h0000_0001, 4'b1100}, {32'h0000_0000, 4'b0010}, {32'h0000_0000, 4'b0110},
                 {32'hF000_F000, 4'b0000}, {32'hFFF0_FFF0, 4'b0000}, {32'h0000_0000, 4'b0011}};
        for (int i = 0; i < 9; i++) begin
            send(ops[i], as[i], bs[i], lat);
            total++;
            if (lat !== NSLICES) begin
                bad++;
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, NSLICES);
            end
            total++;
            if (observe() !== resp_t'(exps[i])) begin
                bad++;
                $display("FAIL directed[%0d] op=%b got=%h exp=%h", i, ops[i], observe(), exps[i]);
            end
            take_result();
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        resp_t       exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(7));
            x   = rand_operand();
            y   = rand_operand();
            exp = model(o, x, y);
            send(o, x, y, lat);
            total++;
            if (lat !== NSLICES || observe() !== exp) begin
                bad++;
                $display("FAIL random[%0d] op=%b a=%h b=%h lat=%0d got=%h exp=%h", i, o, x, y, lat, observe(), exp);
            end
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
            take_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x;
        logic [31:0] y;
        resp_t       exp;
        resp_t       snap;
        int          n;
        x   = $urandom;
        y   = $urandom;
        exp = model(OP_ADD, x, y);
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.a  = x;
        bus.b  = y;
        @(posedge clk); #1;
        // Keep offering junk operations while busy; none may be taken.
        n = 0;
        while (!bus.out_valid && n < TIMEOUT) begin
            bus.op = 3'($urandom_range(7));
            bus.a  = $urandom;
            bus.b  = $urandom;
            @(posedge clk); #1;
            n++;
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL calc_in_ready got=%b exp=0", bus.in_ready);
            end
        end
        snap = observe();
        total++;
        if (n !== NSLICES || snap !== exp) begin
            bad++;
            $display("FAIL bp_result lat=%0d got=%h exp=%h", n, snap, exp);
        end
        for (int c = 0; c < 5; c++) begin
            bus.op = 3'($urandom_range(7));
            bus.a  = $urandom;
            bus.b  = $urandom;
            @(posedge clk); #1;
            total++;
            if (observe() !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h out_valid=%b in_ready=%b", c, observe(), exp, bus.out_valid, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        take_result();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_stray_accept in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        resp_t       exp;
        int          lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            o   = (i % 2 == 0) ? OP_SUB : OP_OR;
            x   = $urandom;
            y   = $urandom;
            exp = model(o, x, y);
            send(o, x, y, lat);
            total++;
            if (lat !== NSLICES || observe() !== exp) begin
                bad++;
                $display("FAIL b2b[%0d] lat=%0d got=%h exp=%h", i, lat, observe(), exp);
            end
            @(posedge clk); #1;
            total++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_ready[%0d] in_ready=%b out_valid=%b exp 1/0", i, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        resp_t exp;
        int    lat;
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.a  = 32'hDEAD_BEEF;
        bus.b  = 32'h1234_5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp = '{result: 32'd0, c_out: 1'b0, overflow: 1'b0, zero: 1'b1, illegal: 1'b0};
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || observe() !== exp) begin
            bad++;
            $display("FAIL mid_reset in_ready=%b out_valid=%b got=%h exp=%h", bus.in_ready, bus.out_valid, observe(), exp);
        end
        send(OP_ADD, 32'd2, 32'd3, lat);
        exp = '{result: 32'd5, c_out: 1'b0, overflow: 1'b0, zero: 1'b0, illegal: 1'b0};
        total++;
        if (lat !== NSLICES || observe() !== exp) begin
            bad++;
            $display("FAIL after_reset_add lat=%0d got=%h exp=%h", lat, observe(), exp);
        end
        take_result();
    endtask

    task automatic test_single_slice();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        resp_t       exp;
        resp_t       got;
        for (int i = 0; i < 6; i++) begin
            o   = (i < 2) ? OP_ADD : ((i < 4) ? OP_SLT : OP_SUB);
            x   = rand_operand();
            y   = rand_operand();
            exp = model(o, x, y);
            bus1.in_valid = 1'b1;
            bus1.op = o;
            bus1.a  = x;
            bus1.b  = y;
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            @(posedge clk); #1;
            got = {bus1.result, bus1.c_out, bus1.overflow, bus1.zero, bus1.illegal};
            total++;
            if (bus1.out_valid !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL single_slice[%0d] out_valid=%b got=%h exp=%h", i, bus1.out_valid, got, exp);
            end
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_AND;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.op        = OP_AND;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_single_slice();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
